// File: rtl/main_net_load_sequencer.sv
// Programs main_net: streams hidden_1/hidden_2/output weights from an external memory into its weight port,
// then presents one captured state vector and waits for main_net to finish.
module main_net_load_sequencer #(
  parameter int DATA_WIDTH                    = 32,
  parameter int LAYER_WIDTH                   = 2,
  parameter int NUMBER_OF_INPUT_NODE          = 2,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
  parameter int NUMBER_OF_OUTPUT_NODE         = 3,
  parameter int WEIGHT_COUNTER_WIDTH          = 11,
  parameter int DATA_COUNTER_WIDTH            = $clog2(NUMBER_OF_HIDDEN_NODE_LAYER_1)
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       i_start,
  input  logic                                       i_mode,
  input  logic [DATA_WIDTH*NUMBER_OF_INPUT_NODE-1:0] i_state,
  output logic                                       o_mem_rd_en,
  output logic [LAYER_WIDTH-1:0]                     o_mem_layer,
  output logic [WEIGHT_COUNTER_WIDTH-1:0]            o_mem_addr,
  input  logic [DATA_WIDTH-1:0]                      i_mem_data,
  output logic                                       o_weight_valid,
  output logic                                       o_rw_weight_select,
  output logic [LAYER_WIDTH-1:0]                     o_weight_layer,
  output logic [WEIGHT_COUNTER_WIDTH-1:0]            o_weight_addr,
  output logic [DATA_WIDTH-1:0]                      o_weight,
  output logic                                       o_data_valid,
  output logic [DATA_COUNTER_WIDTH-1:0]              o_data_addr,
  output logic [DATA_WIDTH-1:0]                      o_data,
  input  logic                                       i_main_net_done,
  output logic                                       o_busy,
  output logic                                       o_done
);

  // Layer word counts: each node stores fan_in weights followed by its bias.
  localparam int N1 = NUMBER_OF_HIDDEN_NODE_LAYER_1 * (NUMBER_OF_INPUT_NODE + 1);
  localparam int N2 = NUMBER_OF_HIDDEN_NODE_LAYER_2 * (NUMBER_OF_HIDDEN_NODE_LAYER_1 + 1);
  localparam int N3 = NUMBER_OF_OUTPUT_NODE * (NUMBER_OF_HIDDEN_NODE_LAYER_2 + 1);

  localparam logic [WEIGHT_COUNTER_WIDTH-1:0] N1_LAST = WEIGHT_COUNTER_WIDTH'(N1 - 1);
  localparam logic [WEIGHT_COUNTER_WIDTH-1:0] N2_LAST = WEIGHT_COUNTER_WIDTH'(N2 - 1);
  localparam logic [WEIGHT_COUNTER_WIDTH-1:0] N3_LAST = WEIGHT_COUNTER_WIDTH'(N3 - 1);
  localparam logic [WEIGHT_COUNTER_WIDTH-1:0] W_ONE   = WEIGHT_COUNTER_WIDTH'(1);
  localparam logic [DATA_COUNTER_WIDTH-1:0]   D_LAST  = DATA_COUNTER_WIDTH'(NUMBER_OF_INPUT_NODE - 1);
  localparam logic [DATA_COUNTER_WIDTH-1:0]   D_ONE   = DATA_COUNTER_WIDTH'(1);

  localparam logic [LAYER_WIDTH-1:0] CODE_L1 = LAYER_WIDTH'(1);
  localparam logic [LAYER_WIDTH-1:0] CODE_L2 = LAYER_WIDTH'(2);
  localparam logic [LAYER_WIDTH-1:0] CODE_L3 = LAYER_WIDTH'(3);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_L1   = 3'd1,
    S_L2   = 3'd2,
    S_L3   = 3'd3,
    S_GAP  = 3'd4,
    S_DATA = 3'd5,
    S_WAIT = 3'd6
  } state_t;

  state_t                          state, state_n;
  logic [WEIGHT_COUNTER_WIDTH-1:0] wcnt;
  logic [DATA_COUNTER_WIDTH-1:0]   dcnt;
  logic [LAYER_WIDTH-1:0]          last_layer;
  logic [DATA_WIDTH-1:0]           state_q [NUMBER_OF_INPUT_NODE];

  logic                            wv_q;
  logic [LAYER_WIDTH-1:0]          wl_q;
  logic [WEIGHT_COUNTER_WIDTH-1:0] wa_q;
  logic                            done_q;

  // All streams here are valid-only: a word transfers on every cycle its valid is high,
  // there is no back-pressure, and layer/address/data are forced to zero while valid is low.
  always_comb begin
    state_n      = state;
    o_mem_rd_en  = 1'b0;
    o_mem_layer  = '0;
    o_mem_addr   = '0;
    o_data_valid = 1'b0;
    o_data_addr  = '0;
    o_data       = '0;
    case (state)
      S_IDLE: begin
        if (i_start) state_n = i_mode ? S_DATA : S_L1;
      end
      S_L1: begin
        o_mem_rd_en = 1'b1;
        o_mem_layer = CODE_L1;
        o_mem_addr  = wcnt;
        if (wcnt == N1_LAST) state_n = S_GAP;
      end
      S_L2: begin
        o_mem_rd_en = 1'b1;
        o_mem_layer = CODE_L2;
        o_mem_addr  = wcnt;
        if (wcnt == N2_LAST) state_n = S_GAP;
      end
      S_L3: begin
        o_mem_rd_en = 1'b1;
        o_mem_layer = CODE_L3;
        o_mem_addr  = wcnt;
        if (wcnt == N3_LAST) state_n = S_GAP;
      end
      S_GAP: begin
        case (last_layer)
          CODE_L1: state_n = S_L2;
          CODE_L2: state_n = S_L3;
          default: state_n = S_DATA;
        endcase
      end
      S_DATA: begin
        o_data_valid = 1'b1;
        o_data_addr  = dcnt;
        for (int k = 0; k < NUMBER_OF_INPUT_NODE; k++) begin
          if (dcnt == DATA_COUNTER_WIDTH'(k)) o_data = state_q[k];
        end
        if (dcnt == D_LAST) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (i_main_net_done) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wcnt       <= '0;
      dcnt       <= '0;
      last_layer <= '0;
      for (int k = 0; k < NUMBER_OF_INPUT_NODE; k++) state_q[k] <= '0;
      wv_q       <= 1'b0;
      wl_q       <= '0;
      wa_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state <= state_n;
      // Address counters clear whenever their phase ends so every layer starts at word 0.
      wcnt  <= (o_mem_rd_en && (state_n == state)) ? wcnt + W_ONE : '0;
      dcnt  <= (o_data_valid && (state_n == S_DATA)) ? dcnt + D_ONE : '0;
      if (o_mem_rd_en) last_layer <= o_mem_layer;
      if ((state == S_IDLE) && i_start) begin
        for (int k = 0; k < NUMBER_OF_INPUT_NODE; k++) begin
          state_q[k] <= i_state[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      wv_q   <= o_mem_rd_en;
      wl_q   <= o_mem_layer;
      wa_q   <= o_mem_addr;
      done_q <= (state == S_WAIT) && i_main_net_done;
    end
  end

  // Read data arrives one cycle after the strobe, aligned with the delayed valid/layer/address.
  assign o_weight_valid     = wv_q;
  assign o_weight_layer     = wl_q;
  assign o_weight_addr      = wa_q;
  assign o_weight           = wv_q ? i_mem_data : '0;
  assign o_rw_weight_select = 1'b0;
  assign o_busy             = (state != S_IDLE);
  assign o_done             = done_q;

endmodule

// File: tb/tb_main_net_load_sequencer.sv
// Directed bench for main_net_load_sequencer: full weight load, data-only run, ignored strobes,
// mid-load reset and completion handshake, against hand-derived cycle-exact expectations.
module tb_main_net_load_sequencer;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic        i_mode;
  logic [63:0] i_state;
  logic        o_mem_rd_en;
  logic [1:0]  o_mem_layer;
  logic [10:0] o_mem_addr;
  logic [31:0] i_mem_data;
  logic        o_weight_valid;
  logic        o_rw_weight_select;
  logic [1:0]  o_weight_layer;
  logic [10:0] o_weight_addr;
  logic [31:0] o_weight;
  logic        o_data_valid;
  logic [4:0]  o_data_addr;
  logic [31:0] o_data;
  logic        i_main_net_done;
  logic        o_busy;
  logic        o_done;

  int n_asserts;
  int n_fail;
  logic [31:0] exp_q[$];

  main_net_load_sequencer dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_start            (i_start),
    .i_mode             (i_mode),
    .i_state            (i_state),
    .o_mem_rd_en        (o_mem_rd_en),
    .o_mem_layer        (o_mem_layer),
    .o_mem_addr         (o_mem_addr),
    .i_mem_data         (i_mem_data),
    .o_weight_valid     (o_weight_valid),
    .o_rw_weight_select (o_rw_weight_select),
    .o_weight_layer     (o_weight_layer),
    .o_weight_addr      (o_weight_addr),
    .o_weight           (o_weight),
    .o_data_valid       (o_data_valid),
    .o_data_addr        (o_data_addr),
    .o_data             (o_data),
    .i_main_net_done    (i_main_net_done),
    .o_busy             (o_busy),
    .o_done             (o_done)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Weight memory model: word = (layer<<16)|addr, valid the cycle after the strobe; junk otherwise.
  always @(posedge clk) begin
    if (o_mem_rd_en) i_mem_data <= {14'd0, o_mem_layer, 5'd0, o_mem_addr};
    else             i_mem_data <= 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},     32'(o_busy), 32'd0);
    check({tag, "_rd_en"},    32'(o_mem_rd_en), 32'd0);
    check({tag, "_mlayer"},   32'(o_mem_layer), 32'd0);
    check({tag, "_maddr"},    32'(o_mem_addr), 32'd0);
    check({tag, "_wvalid"},   32'(o_weight_valid), 32'd0);
    check({tag, "_rwsel"},    32'(o_rw_weight_select), 32'd0);
    check({tag, "_wlayer"},   32'(o_weight_layer), 32'd0);
    check({tag, "_waddr"},    32'(o_weight_addr), 32'd0);
    check({tag, "_weight"},   o_weight, 32'd0);
    check({tag, "_dvalid"},   32'(o_data_valid), 32'd0);
    check({tag, "_daddr"},    32'(o_data_addr), 32'd0);
    check({tag, "_data"},     o_data, 32'd0);
    check({tag, "_done"},     32'(o_done), 32'd0);
  endtask

  // Expected read issue in cycle c after start: {rd_en, layer, addr}.
  // L1 cycles 1..96, GAP 97, L2 98..1153, GAP 1154, L3 1155..1253, GAP 1254, DATA 1255..1256.
  function automatic logic [13:0] rd_exp(input int c);
    if (c >= 1 && c <= 96)      return {1'b1, 2'd1, 11'(c - 1)};
    if (c >= 98 && c <= 1153)   return {1'b1, 2'd2, 11'(c - 98)};
    if (c >= 1155 && c <= 1253) return {1'b1, 2'd3, 11'(c - 1155)};
    return 14'd0;
  endfunction

  initial begin
    logic [13:0] r;
    logic [13:0] w;
    logic [31:0] ew;
    int err_rd, err_wt, err_word, err_dat, err_ctl, err_wait;
    int cnt_l[4];

    n_asserts = 0;
    n_fail    = 0;
    err_rd = 0; err_wt = 0; err_word = 0; err_dat = 0; err_ctl = 0; err_wait = 0;
    for (int i = 0; i < 4; i++) cnt_l[i] = 0;
    rst_n = 1'b0; i_start = 1'b0; i_mode = 1'b0; i_state = '0; i_main_net_done = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_reset");

    // T3: data-only run; element 0 sits in the low word
    i_state = {32'h3BA54102, 32'hBF0BB4B6};
    i_mode  = 1'b1;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_mode  = 1'b0;
    check("t3_dvalid0", 32'(o_data_valid), 32'd1);
    check("t3_daddr0",  32'(o_data_addr), 32'd0);
    check("t3_data0",   o_data, 32'hBF0BB4B6);
    check("t3_busy",    32'(o_busy), 32'd1);
    check("t3_no_read", 32'(o_mem_rd_en), 32'd0);
    @(negedge clk);
    check("t3_dvalid1", 32'(o_data_valid), 32'd1);
    check("t3_daddr1",  32'(o_data_addr), 32'd1);
    check("t3_data1",   o_data, 32'h3BA54102);
    @(negedge clk);
    check("t3_wait_dvalid", 32'(o_data_valid), 32'd0);
    check("t3_wait_data",   o_data, 32'd0);
    check("t3_wait_busy",   32'(o_busy), 32'd1);
    i_main_net_done = 1'b1;
    @(negedge clk);
    i_main_net_done = 1'b0;
    check("t3_done",      32'(o_done), 32'd1);
    check("t3_done_busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    check("t3_done_drop", 32'(o_done), 32'd0);

    // T1/T2/T4: full load, stray start in L2 and stray done in L3
    i_state = {32'h40000000, 32'h3F800000};
    i_mode  = 1'b0;
    i_start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 1256; c++) begin
      if (c == 600) begin
        i_start = 1'b1;
        i_mode  = 1'b1;
        i_state = {32'hFFFFFFFF, 32'hFFFFFFFF};
      end else begin
        i_start = 1'b0;
      end
      i_main_net_done = (c == 1200);

      r = rd_exp(c);
      w = rd_exp(c - 1);
      if ({o_mem_rd_en, o_mem_layer, o_mem_addr} !== r) err_rd++;
      if (r[13]) exp_q.push_back({14'd0, r[12:11], 5'd0, r[10:0]});
      if ({o_weight_valid, o_weight_layer, o_weight_addr} !== w) err_wt++;
      if (o_weight_valid) begin
        cnt_l[o_weight_layer]++;
        if (o_weight !== {14'd0, o_weight_layer, 5'd0, o_weight_addr}) err_word++;
      end
      if (w[13]) begin
        if (exp_q.size() == 0) err_word++;
        else begin
          ew = exp_q.pop_front();
          if (o_weight !== ew) err_word++;
        end
      end else if (o_weight !== 32'd0) err_word++;

      if (c == 1255) begin
        check("t1_first_dvalid", 32'(o_data_valid), 32'd1);
        check("t1_first_daddr",  32'(o_data_addr), 32'd0);
        check("t1_first_data",   o_data, 32'h3F800000);
      end else if (c == 1256) begin
        check("t1_second_dvalid", 32'(o_data_valid), 32'd1);
        check("t1_second_daddr",  32'(o_data_addr), 32'd1);
        check("t1_second_data",   o_data, 32'h40000000);
      end else if (o_data_valid !== 1'b0 || o_data_addr !== 5'd0 || o_data !== 32'd0) begin
        err_dat++;
      end
      if (o_busy !== 1'b1 || o_done !== 1'b0 || o_rw_weight_select !== 1'b0) err_ctl++;
      @(negedge clk);
    end
    i_mode = 1'b0;
    i_main_net_done = 1'b0;
    check("t1_count_l1",   32'(cnt_l[1]), 32'd96);
    check("t1_count_l2",   32'(cnt_l[2]), 32'd1056);
    check("t1_count_l3",   32'(cnt_l[3]), 32'd99);
    check("t1_count_none", 32'(cnt_l[0]), 32'd0);
    check("t1_read_seq_errs",   32'(err_rd), 32'd0);
    check("t1_weight_seq_errs", 32'(err_wt), 32'd0);
    check("t2_weight_word_errs", 32'(err_word), 32'd0);
    check("t2_queue_drained",   32'(exp_q.size()), 32'd0);
    check("t4_data_idle_errs",  32'(err_dat), 32'd0);
    check("t4_ctrl_errs",       32'(err_ctl), 32'd0);

    // T6: WAIT held 40 cycles, then done
    for (int c = 1257; c <= 1296; c++) begin
      if (o_busy !== 1'b1 || o_done !== 1'b0 || o_data_valid !== 1'b0 ||
          o_mem_rd_en !== 1'b0 || o_weight_valid !== 1'b0) err_wait++;
      if (c == 1296) i_main_net_done = 1'b1;
      @(negedge clk);
    end
    i_main_net_done = 1'b0;
    check("t6_wait_errs", 32'(err_wait), 32'd0);
    check("t6_done",      32'(o_done), 32'd1);
    check("t6_busy_drop", 32'(o_busy), 32'd0);
    @(negedge clk);
    check("t6_done_pulse", 32'(o_done), 32'd0);
    check("t6_busy_idle",  32'(o_busy), 32'd0);

    // T5: reset at L2 address 500, then restart
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (597) @(negedge clk);
    check("t5_at_l2_addr",  32'(o_mem_addr), 32'd500);
    check("t5_at_l2_layer", 32'(o_mem_layer), 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle("t5_abort");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("t5_released");
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("t5_restart_rd",     32'(o_mem_rd_en), 32'd1);
    check("t5_restart_layer",  32'(o_mem_layer), 32'd1);
    check("t5_restart_addr",   32'(o_mem_addr), 32'd0);
    check("t5_restart_wvalid", 32'(o_weight_valid), 32'd0);
    @(negedge clk);
    check("t5_next_addr",   32'(o_mem_addr), 32'd1);
    check("t5_wvalid",      32'(o_weight_valid), 32'd1);
    check("t5_wlayer",      32'(o_weight_layer), 32'd1);
    check("t5_waddr",       32'(o_weight_addr), 32'd0);
    check("t5_weight",      o_weight, 32'h00010000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
